// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage definitions: NOP encoding, fetch FSM states and the
// instruction-buffer entry layout used by ifetch_buf.
package rv_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_TRAP  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage, occupancy count and a clear input.
// The head entry is readable combinationally whenever count is non-zero.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;

  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wrPtr <= nextPtr(r_wrPtr);
      if (pop)  r_rdPtr <= nextPtr(r_rdPtr);
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; validity is carried entirely by r_count.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wrPtr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && !pop && (r_count == CW'(DEPTH))));
      assert (!(pop && (r_count == '0)));
    end
  end

  assign head  = r_mem[r_rdPtr];
  assign count = r_count;

endmodule

// File: rtl/ifetch_buf.sv
// Instruction-fetch buffer: issues in-order imem requests for pc_in under a credit
// limit, queues responses for decode and drops in-flight fetches on flush.
// Optional: define IFETCH_MISALIGN_EN to trap misaligned PCs (adds id_misalign).
module ifetch_buf #(
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUT    = 2,
  parameter logic [31:0] NOP_INSTR  = rv_fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_advance,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_ready
`ifdef IFETCH_MISALIGN_EN
  ,
  output logic        id_misalign
`endif
);

  import rv_fetch_pkg::*;

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t r_state;
  fetch_state_t w_nextState;
  logic [OW-1:0] r_drop;
  logic [OW-1:0] w_outstanding;
  logic [OW-1:0] w_outNext;
  logic [FW-1:0] w_fifoCount;
  logic [31:0]   w_tagPc;
  fetch_entry_t  w_head;
  fetch_entry_t  w_pushEntry;
  logic          w_credit;
  logic          w_misPc;
  logic          w_misPush;
  logic          w_accept;
  logic          w_rsp;
  logic          w_rspKeep;
  logic          w_push;
  logic          w_pop;

  // Credit counts reserved FIFO slots for in-flight fetches, so responses never stall.
  assign w_credit = !rst && (r_state == S_RUN) && !flush
                    && (32'(w_outstanding) < MAX_OUT)
                    && (32'(w_outstanding) + 32'(w_fifoCount) < FIFO_DEPTH);

`ifdef IFETCH_MISALIGN_EN
  assign w_misPc   = (pc_in[1:0] != 2'b00);
  assign w_misPush = w_credit && w_misPc && (w_outstanding == '0);
  assign id_misalign = id_valid && w_head.misalign;
`else
  logic w_unusedMisalign;
  assign w_misPc   = 1'b0;
  assign w_misPush = 1'b0;
  assign w_unusedMisalign = w_head.misalign;
`endif

  assign imem_req_valid = w_credit && !w_misPc;
  assign imem_req_addr  = (rst || (r_state == S_RST)) ? '0 : {pc_in[31:2], 2'b00};
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign pc_advance     = w_accept || w_misPush;

  // Responses with no tracked request (e.g. issued before a reset) are ignored.
  assign w_rsp     = !rst && imem_rsp_valid && (w_outstanding != '0);
  assign w_rspKeep = w_rsp && (r_drop == '0) && !flush;
  assign w_push    = w_rspKeep || w_misPush;
  assign w_pop     = id_valid && id_ready && !flush;
  assign w_outNext = w_outstanding + OW'(w_accept) - OW'(w_rsp);

  always_comb begin
    w_pushEntry = '{pc: w_tagPc, instr: imem_rsp_data, misalign: 1'b0};
    if (w_misPush) w_pushEntry = '{pc: pc_in, instr: NOP_INSTR, misalign: 1'b1};
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUT)
  ) u_tagQ (
    .clk       (clk),
    .rst       (rst),
    .push      (w_accept),
    .push_data (pc_in),
    .pop       (w_rsp),
    .flush     (1'b0),
    .head      (w_tagPc),
    .count     (w_outstanding)
  );

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_instrBuf (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_pushEntry),
    .pop       (w_pop),
    .flush     (flush),
    .head      (w_head),
    .count     (w_fifoCount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RST;
      r_drop  <= '0;
    end else begin
      r_state <= w_nextState;
      if (flush) begin
        r_drop <= w_outNext;
      end else if (w_rsp && (r_drop != '0)) begin
        r_drop <= r_drop - OW'(1);
      end
    end
  end

  // A flush always restarts tracking; DRAIN is needed only while pre-flush fetches remain.
  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = (w_outNext == '0) ? S_RUN : S_DRAIN;
    end else begin
      case (r_state)
        S_RST:   w_nextState = S_RUN;
        S_RUN:   if (w_misPush) w_nextState = S_TRAP;
        S_DRAIN: if ((r_drop == '0) || (w_rsp && (r_drop == OW'(1)))) w_nextState = S_RUN;
        default: w_nextState = r_state;
      endcase
    end
  end

  assign id_valid = !rst && (w_fifoCount != '0);
  assign id_pc    = id_valid ? w_head.pc : '0;
  assign id_instr = id_valid ? w_head.instr : NOP_INSTR;

endmodule
